// File: rtl/vinsn_issue_queue.sv
// Vector instruction issue queue: FIFO between scalar issue and the vector core,
// with an issued-but-not-done cap and flush.
package vinsn_pkg;
  typedef logic [7:0] insn_id_t;
  typedef struct packed {
    logic [7:0]  vtype;
    logic [15:0] vl;
  } vec_context_t;
endpackage

module vinsn_issue_queue
  import vinsn_pkg::*;
#(
  parameter int Depth       = 4,
  parameter int MaxInflight = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               valid_i,
  output logic                               ready_o,
  input  logic [31:0]                        insn_i,
  input  insn_id_t                           insn_id_i,
  input  vec_context_t                       vec_context_i,
  input  logic                               flush_i,
  output logic                               issue_valid_o,
  input  logic                               issue_ready_i,
  output logic [31:0]                        issue_insn_o,
  output insn_id_t                           issue_insn_id_o,
  output vec_context_t                       issue_vec_context_o,
  input  logic                               done_i,
  output logic [$clog2(Depth+1)-1:0]         count_o,
  output logic [$clog2(MaxInflight+1)-1:0]   inflight_o
);

  localparam int PW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CW = $clog2(Depth+1);
  localparam int IW = $clog2(MaxInflight+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(Depth);
  localparam logic [IW-1:0] MAX_C   = IW'(MaxInflight);
  localparam logic [PW-1:0] LAST_C  = PW'(Depth-1);

  logic [31:0]  insn_q [Depth];
  insn_id_t     id_q   [Depth];
  vec_context_t ctx_q  [Depth];

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [IW-1:0] inflight_q;

  logic push, pop;

  assign ready_o = !rst_i && !flush_i
                && (count_q < DEPTH_C);
  assign issue_valid_o = !rst_i && !flush_i
                      && (count_q != '0)
                      && (inflight_q < MAX_C);

  assign push = valid_i && ready_o;
  assign pop  = issue_valid_o && issue_ready_i;

  assign issue_insn_o        = insn_q[rd_ptr_q];
  assign issue_insn_id_o     = id_q[rd_ptr_q];
  assign issue_vec_context_o = ctx_q[rd_ptr_q];

  assign count_o    = count_q;
  assign inflight_o = inflight_q;

  // Payload is never reset; only valid entries are ever presented.
  always_ff @(posedge clk_i) begin
    if (push) begin
      insn_q[wr_ptr_q] <= insn_i;
      id_q[wr_ptr_q]   <= insn_id_i;
      ctx_q[wr_ptr_q]  <= vec_context_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
      // done_i at zero with no pop saturates.
      if (pop && !done_i) begin
        inflight_q <= inflight_q + 1'b1;
      end else if (done_i && !pop && inflight_q != '0) begin
        inflight_q <= inflight_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vinsn_issue_queue.sv
// Directed testbench for vinsn_issue_queue (Depth=4, MaxInflight=2).
module tb_vinsn_issue_queue;
  import vinsn_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid;
  logic         ready;
  logic [31:0]  insn;
  insn_id_t     id;
  vec_context_t ctx;
  logic         flush;
  logic         iv;
  logic         ir;
  logic [31:0]  iinsn;
  insn_id_t     iid;
  vec_context_t ictx;
  logic         done;
  logic [2:0]   count;
  logic [1:0]   inflight;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vinsn_issue_queue #(.Depth(4), .MaxInflight(2)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .valid_i(valid), .ready_o(ready),
    .insn_i(insn), .insn_id_i(id),
    .vec_context_i(ctx), .flush_i(flush),
    .issue_valid_o(iv), .issue_ready_i(ir),
    .issue_insn_o(iinsn), .issue_insn_id_o(iid),
    .issue_vec_context_o(ictx), .done_i(done),
    .count_o(count), .inflight_o(inflight)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input int i);
    valid = v;
    id    = insn_id_t'(i);
    insn  = 32'hA000_0000 + 32'(i);
    ctx   = '{vtype: 8'(i + 8'h10), vl: 16'(i * 3)};
  endtask

  task automatic test_reset();
    rst = 1; put(0, 0); flush = 0; ir = 0; done = 0;
    cyc(); cyc();
    n_cmp++; if (ready !== 1'b0) begin
      $display("FAIL rst_ready: got %b want 0", ready); n_bad++; end
    n_cmp++; if (iv !== 1'b0) begin
      $display("FAIL rst_iv: got %b want 0", iv); n_bad++; end
    n_cmp++; if (count !== 3'd0) begin
      $display("FAIL rst_count: got %0d want 0", count); n_bad++; end
    n_cmp++; if (inflight !== 2'd0) begin
      $display("FAIL rst_inflight: got %0d want 0", inflight); n_bad++; end
    rst = 0;
    cyc();
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 4; i++) begin
      put(1, i);
      #1;
      n_cmp++; if (ready !== 1'b1) begin
        $display("FAIL fill_ready%0d: got %b want 1", i, ready); n_bad++; end
      n_cmp++; if (iv !== (i > 1)) begin
        $display("FAIL fill_iv%0d: got %b want %b", i, iv, i > 1); n_bad++; end
      cyc();
    end
    put(0, 0);
    #1;
    n_cmp++; if (count !== 3'd4) begin
      $display("FAIL fill_count: got %0d want 4", count); n_bad++; end
    n_cmp++; if (ready !== 1'b0) begin
      $display("FAIL fill_full_ready: got %b want 0", ready); n_bad++; end
    n_cmp++; if (iid !== 8'd1) begin
      $display("FAIL fill_head: got %0d want 1", iid); n_bad++; end
    n_cmp++; if (iinsn !== 32'hA000_0001) begin
      $display("FAIL fill_insn: got %h want a0000001", iinsn); n_bad++; end
    n_cmp++; if (ictx !== 24'h11_0003) begin
      $display("FAIL fill_ctx: got %h want 110003", ictx); n_bad++; end
  endtask

  task automatic test_full_pop();
    put(1, 5); ir = 1;
    #1;
    n_cmp++; if (ready !== 1'b0 || iv !== 1'b1 || iid !== 8'd1) begin
      $display("FAIL fullpop_cycle: got r=%b v=%b id=%0d want r=0 v=1 id=1",
               ready, iv, iid); n_bad++; end
    cyc();
    put(0, 0); ir = 0;
    #1;
    n_cmp++; if (count !== 3'd3 || ready !== 1'b1 || iid !== 8'd2) begin
      $display("FAIL fullpop_next: got c=%0d r=%b id=%0d want c=3 r=1 id=2",
               count, ready, iid); n_bad++; end
    n_cmp++; if (inflight !== 2'd1) begin
      $display("FAIL fullpop_inflight: got %0d want 1", inflight); n_bad++; end
  endtask

  task automatic test_max_inflight();
    done = 1; put(1, 5);
    cyc();
    done = 0; put(0, 0); ir = 1;
    #1;
    n_cmp++; if (inflight !== 2'd0 || count !== 3'd4) begin
      $display("FAIL mi_setup: got i=%0d c=%0d want i=0 c=4",
               inflight, count); n_bad++; end
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (iv !== 1'b1 || iid !== insn_id_t'(2 + k)) begin
        $display("FAIL mi_issue%0d: got v=%b id=%0d want v=1 id=%0d",
                 k, iv, iid, 2 + k); n_bad++; end
      cyc();
    end
    n_cmp++; if (iv !== 1'b0 || count !== 3'd2 || inflight !== 2'd2) begin
      $display("FAIL mi_capped: got v=%b c=%0d i=%0d want v=0 c=2 i=2",
               iv, count, inflight); n_bad++; end
    ir = 0; done = 1;
    cyc();
    done = 0;
    #1;
    n_cmp++; if (inflight !== 2'd1 || iv !== 1'b1 || iid !== 8'd4) begin
      $display("FAIL mi_done: got i=%0d v=%b id=%0d want i=1 v=1 id=4",
               inflight, iv, iid); n_bad++; end
    ir = 1; done = 1;
    cyc();
    ir = 0; done = 0;
    #1;
    n_cmp++; if (inflight !== 2'd1 || count !== 3'd1 || iid !== 8'd5) begin
      $display("FAIL mi_popdone: got i=%0d c=%0d id=%0d want i=1 c=1 id=5",
               inflight, count, iid); n_bad++; end
  endtask

  task automatic test_flush();
    put(1, 6); ir = 1;
    cyc();
    ir = 0; put(1, 7);
    cyc();
    put(1, 8);
    cyc();
    put(0, 0);
    #1;
    n_cmp++; if (count !== 3'd3 || inflight !== 2'd2) begin
      $display("FAIL fl_setup: got c=%0d i=%0d want c=3 i=2",
               count, inflight); n_bad++; end
    flush = 1; put(1, 9); ir = 1; done = 1;
    #1;
    n_cmp++; if (ready !== 1'b0 || iv !== 1'b0) begin
      $display("FAIL fl_cycle: got r=%b v=%b want r=0 v=0", ready, iv);
      n_bad++; end
    cyc();
    flush = 0; put(0, 0); ir = 0; done = 0;
    #1;
    n_cmp++; if (count !== 3'd0 || inflight !== 2'd0 || iv !== 1'b0) begin
      $display("FAIL fl_after: got c=%0d i=%0d v=%b want c=0 i=0 v=0",
               count, inflight, iv); n_bad++; end
    put(1, 7);
    #1;
    n_cmp++; if (iv !== 1'b0) begin
      $display("FAIL fl_nobypass: got v=%b want 0", iv); n_bad++; end
    cyc();
    put(0, 0);
    #1;
    n_cmp++; if (iv !== 1'b1 || iid !== 8'd7 || count !== 3'd1) begin
      $display("FAIL fl_push7: got v=%b id=%0d c=%0d want v=1 id=7 c=1",
               iv, iid, count); n_bad++; end
  endtask

  task automatic test_back_to_back();
    int pushed = 0;
    int popped = 0;
    int cycles = 0;
    logic last_pop = 0;
    flush = 1;
    cyc();
    flush = 0;
    while (popped < 10 && cycles < 40) begin
      put(pushed < 10, pushed);
      ir = 1; done = last_pop;
      #1;
      if (valid && ready) pushed++;
      last_pop = iv;
      if (iv) begin
        n_cmp++; if (iid !== insn_id_t'(popped)) begin
          $display("FAIL b2b_id%0d: got %0d want %0d", popped, iid, popped);
          n_bad++; end
        popped++;
      end
      n_cmp++; if (inflight > 2'd1) begin
        $display("FAIL b2b_inflight: got %0d want <=1", inflight); n_bad++; end
      cyc();
      cycles++;
    end
    n_cmp++; if (popped != 10) begin
      $display("FAIL b2b_timeout: got %0d pops want 10", popped); n_bad++; end
    put(0, 0); ir = 0; done = last_pop;
    cyc();
    done = 0;
    #1;
    n_cmp++; if (count !== 3'd0 || inflight !== 2'd0) begin
      $display("FAIL b2b_end: got c=%0d i=%0d want c=0 i=0",
               count, inflight); n_bad++; end
  endtask

  task automatic test_underflow_reset();
    done = 1;
    cyc();
    done = 0;
    #1;
    n_cmp++; if (inflight !== 2'd0) begin
      $display("FAIL uf_inflight: got %0d want 0", inflight); n_bad++; end
    put(1, 20);
    cyc();
    put(1, 21); ir = 1;
    cyc();
    put(0, 0); ir = 0;
    #1;
    n_cmp++; if (count !== 3'd1 || inflight !== 2'd1) begin
      $display("FAIL rs_setup: got c=%0d i=%0d want c=1 i=1",
               count, inflight); n_bad++; end
    rst = 1; put(1, 22); ir = 1;
    #1;
    n_cmp++; if (ready !== 1'b0 || iv !== 1'b0) begin
      $display("FAIL rs_during: got r=%b v=%b want r=0 v=0", ready, iv);
      n_bad++; end
    cyc();
    rst = 0; put(0, 0); ir = 0;
    #1;
    n_cmp++; if (count !== 3'd0 || inflight !== 2'd0
                 || ready !== 1'b1 || iv !== 1'b0) begin
      $display("FAIL rs_after: got c=%0d i=%0d r=%b v=%b want c=0 i=0 r=1 v=0",
               count, inflight, ready, iv); n_bad++; end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_pop();
    test_max_inflight();
    test_flush();
    test_back_to_back();
    test_underflow_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
